hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Consumer side of the decode stage's hazard flags (rs1/rs2 hazard_on) and its rd/reg_wren outputs.
- Tracks destination registers of in-flight instructions in EX/MEM/WB and compares them against the source registers of the instruction in ID.
- Raises stall to IF/ID and injects a bubble into EX until the producer retires.
- Also handles branch flush from EX so killed instructions never enter the scoreboard.

Parameters:
DEPTH, 3, number of tracked stages after ID (slot 0 = EX, slot DEPTH-1 = WB)
WB_BYPASS, 1, 1 = regfile write-then-read in same cycle, so the WB slot is excluded from compare; 0 = WB slot compared

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  synchronous, active-low reset
i_id_valid  in  1  ID holds a real instruction
i_rs1_addr  in  5  inst[19:15] of ID instruction
i_rs2_addr  in  5  inst[24:20] of ID instruction
i_rs1_hazard_on  in  1  ID instruction reads rs1
i_rs2_hazard_on  in  1  ID instruction reads rs2
i_rd_addr  in  5  inst[11:7] of ID instruction
i_reg_wren  in  1  ID instruction writes rd
i_flush  in  1  taken branch/jump resolved in EX this cycle
o_stall  out  1  hold PC and IF/ID register
o_bubble  out  1  load NOP into ID/EX register
o_pend_vec  out  32  bit r set = register r has an in-flight tracked writer

Behaviour:
- Interface: one clock, i_clk; reset synchronous, active-low, i_reset_n.
- State: DEPTH slots, each {valid, rd[4:0]}. Slots shift every cycle (downstream never stalls): slot k+1 <= slot k.
- Slot 0 load:
  - Written with {1, i_rd_addr} when issue = i_id_valid & ~o_stall & ~i_flush & i_reg_wren & (i_rd_addr != 0).
  - Otherwise written with {0, 0} (bubble, x0 writer, non-writer, or flushed).
- Hazard compare:
  - hit1 = i_rs1_hazard_on & (i_rs1_addr != 0) & any active slot with valid & rd == i_rs1_addr.
  - hit2 is the same for rs2.
  - Active slots: 0..DEPTH-1 when WB_BYPASS=0; 0..DEPTH-2 when WB_BYPASS=1.
- Outputs (combinational):
  - o_stall = i_id_valid & ~i_flush & (hit1 | hit2).
  - o_bubble = o_stall | i_flush.
  - o_pend_vec = OR of one-hot(rd) over all valid slots, including WB regardless of WB_BYPASS. Bit 0 is always 0.
- Flush priority:
  - i_flush overrides hazard: o_stall = 0, the ID instruction is not pushed, o_bubble = 1.
  - Existing slots keep shifting. The branch itself is already in slot 0 or earlier.
- Stall duration:
  - Stall persists until the matching producer leaves the active window.
  - Back-to-back dependency, WB_BYPASS=1, DEPTH=3: 2 stall cycles. WB_BYPASS=0: 3 stall cycles.
- Multiple matching slots: stall continues until the youngest matching producer leaves the window.
- rs1 == rs2 with both hazard_on: single stall condition, no double counting.
- Reset: all slots invalid, rd = 0.
  - o_stall = 0, o_bubble = 0, o_pend_vec = 0 (given i_id_valid = 0 / i_flush = 0 during reset).
  - Reset mid-stall clears all pending writers; the first cycle after reset sees no hazard.
- Latency: stall decision is zero-cycle (same cycle as ID presentation). Scoreboard update takes effect next cycle.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt[31:0], incremented on each cycle with o_stall = 1, reset to 0.
  - Saturates at 32'hFFFF_FFFF (no wrap).
  - Adds output o_flush_cnt[31:0] with identical rules, counting i_flush cycles.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Shared package (pipeline_pkg):
  - REG_ADDR_W = 5, NUM_REGS = 32, XLEN = 32.
  - typedef sb_slot_t {logic valid; logic [4:0] rd;}.
  - Stage index constants SLOT_EX = 0, SLOT_MEM = 1, SLOT_WB = 2.
- One natural sub-module: sb_match, the combinational compare of one source address against the slot array, returning hit. Instantiated twice (rs1, rs2).
- Shift register and counters stay in the top module.

Test Plan:
- Reset: i_reset_n = 0 for 2 cycles with prior pending writers → o_pend_vec = 0, o_stall = 0 in the first cycle after release.
- RAW back-to-back, WB_BYPASS=1: issue rd=5 wren; next ID rs1=5 hazard_on → o_stall = 1 for exactly 2 cycles, o_bubble = 1 same cycles, third cycle o_stall = 0. Repeat with WB_BYPASS=0 → 3 cycles.
- x0 and non-users:
  - Producer rd=0 wren → no stall.
  - Producer rd=7 followed by consumer rs2=7 with i_rs2_hazard_on = 0 → no stall.
  - Producer rd=7 with i_reg_wren = 0 → no stall, o_pend_vec[7] = 0.
- Flush: producer rd=9 in slot 0; ID instruction rs1=9 with i_flush = 1 → o_stall = 0, o_bubble = 1, nothing pushed for the ID instruction.
- Multiple producers: rd=3 at cycle t and rd=3 again at t+1, consumer rs1=3 → stall until the second producer leaves the window; o_pend_vec[3] stays 1 throughout.
- HAZARD_STALL_CNT_EN defined: run the RAW case twice plus one flush → o_stall_cnt = 4 (WB_BYPASS=1), o_flush_cnt = 1. Force the counter to FFFF_FFFF → holds on further stalls.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file geometry, scoreboard slot type,
// and stage index constants for the post-ID pipeline.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    // Stage positions in the scoreboard shift register
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    // One in-flight destination register
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// sb_match: compares one source register against the active scoreboard slots.
// Slot 0 is EX; only slots 0..ACTIVE-1 take part in the compare.
module sb_match
    import pipeline_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int ACTIVE = 2
) (
    input  sb_slot_t [DEPTH-1:0]  slots,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_en,
    output logic                  hit
);

    // x0 is never a real dependency; unused sources never match
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < ACTIVE; k++) begin
            if (slots[k].valid && (slots[k].rd == src_addr))
                hit = 1'b1;
        end
        if (!src_en || (src_addr == '0))
            hit = 1'b0;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks rd of instructions in EX..WB and stalls ID on a
// RAW dependency until the producer leaves the compare window. A taken
// branch flush from EX kills the ID instruction (bubble, nothing recorded).
// Optional build macro HAZARD_STALL_CNT_EN adds saturating stall/flush
// cycle counters.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic                  i_rs1_hazard_on,
    input  logic                  i_rs2_hazard_on,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_reg_wren,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_bubble,
    output logic [NUM_REGS-1:0]   o_pend_vec
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]           o_stall_cnt,
    output logic [31:0]           o_flush_cnt
`endif
);

    // With write-then-read regfile the WB writer is already visible to ID
    localparam int ACTIVE = WB_BYPASS ? DEPTH - 1 : DEPTH;

    sb_slot_t [DEPTH-1:0] slots;
    logic                 hit1, hit2;
    logic                 issue;

    sb_match #(.DEPTH(DEPTH), .ACTIVE(ACTIVE)) u_match_rs1 (
        .slots    (slots),
        .src_addr (i_rs1_addr),
        .src_en   (i_rs1_hazard_on),
        .hit      (hit1)
    );

    sb_match #(.DEPTH(DEPTH), .ACTIVE(ACTIVE)) u_match_rs2 (
        .slots    (slots),
        .src_addr (i_rs2_addr),
        .src_en   (i_rs2_hazard_on),
        .hit      (hit2)
    );

    // Zero-cycle hazard decision; flush wins over stall
    always_comb begin
        o_stall  = i_id_valid & ~i_flush & (hit1 | hit2);
        o_bubble = o_stall | i_flush;
        issue    = i_id_valid & ~o_stall & ~i_flush & i_reg_wren & (i_rd_addr != '0);
    end

    // Pending-writer map covers every valid slot, WB included
    always_comb begin
        o_pend_vec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slots[k].valid)
                o_pend_vec[slots[k].rd] = 1'b1;
        end
        o_pend_vec[0] = 1'b0;
    end

    // Downstream never stalls: shift every cycle, load EX slot from ID
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            slots <= '0;
        end else begin
            slots[0] <= issue ? sb_slot_t'{valid: 1'b1, rd: i_rd_addr} : '0;
            for (int k = 1; k < DEPTH; k++)
                slots[k] <= slots[k-1];
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating event counters for stall and flush cycles
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (o_stall && (o_stall_cnt != 32'hFFFF_FFFF))
                o_stall_cnt <= o_stall_cnt + 32'd1;
            if (i_flush && (o_flush_cnt != 32'hFFFF_FFFF))
                o_flush_cnt <= o_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
